extadc_serial_frontend: RTL

- Sits directly upstream of the ExtADC sensor application in the WSN SoC.
- Converts the ExtADC convert-request handshake (AdcDoConvert / AdcConvComplete / 10-bit AdcValue) into a read-only serial frame to an external SPI-style ADC: CS_n, SCLK, MISO, MCP3001-class framing.
- Assembles the MSB-first result and presents it together with a completion flag, held until the requester releases the request.

---
 rtl/extadc_frontend_pkg.sv | 23 ++
 rtl/extadc_serial_frontend_if.sv | 28 ++
 rtl/extadc_phase_timer.sv | 39 +++
 rtl/extadc_serial_frontend.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/extadc_frontend_pkg.sv
// Shared types and constants for the ExtADC serial front end.
// Holds the frame FSM state type, counter width helper and default parameters.
package extadc_frontend_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLow,
        StHigh,
        StHold,
        StDone
    } state_e;

    localparam int DefClkDiv    = 4;
    localparam int DefLeadBits  = 3;
    localparam int DefDataWidth = 10;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/extadc_serial_frontend_if.sv
// Convert-request handshake between the ExtADC application and the serial front end.
// The master is the requester; the slave is the front end.
interface extadc_serial_frontend_if
    import extadc_frontend_pkg::*;
#(
    parameter int DataWidth = DefDataWidth
);

    logic                 AdcDoConvert;
    logic                 AdcConvComplete;
    logic [DataWidth-1:0] AdcValue;
    logic                 Busy;

    modport master (
        output AdcDoConvert,
        input  AdcConvComplete,
        input  AdcValue,
        input  Busy
    );

    modport slave (
        input  AdcDoConvert,
        output AdcConvComplete,
        output AdcValue,
        output Busy
    );

endinterface

// File: rtl/extadc_phase_timer.sv
// Loadable down-counter producing a one-cycle phase_end strobe every ClkDiv cycles.
// restart_i reloads the counter so the first strobe comes ClkDiv cycles after release.
module extadc_phase_timer
    import extadc_frontend_pkg::*;
#(
    parameter int ClkDiv = DefClkDiv
) (
    input  logic Clk_i,
    input  logic Reset_i,
    input  logic restart_i,
    input  logic enable_i,
    output logic phase_end_o
);

    localparam int              CntW   = cnt_width(ClkDiv);
    localparam logic [CntW-1:0] Reload = CntW'(ClkDiv - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = Reload;
        end else if (enable_i) begin
            cnt_d = (cnt_q == '0) ? Reload : cnt_q - CntW'(1);
        end
    end

    assign phase_end_o = enable_i && !restart_i && (cnt_q == '0);

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            cnt_q <= Reload;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/extadc_serial_frontend.sv
// Turns the ExtADC convert handshake into a read-only SPI frame (MCP3001-style)
// and returns the MSB-first result, held with a completion flag until released.
module extadc_serial_frontend
    import extadc_frontend_pkg::*;
#(
    parameter int ClkDiv    = DefClkDiv,
    parameter int LeadBits  = DefLeadBits,
    parameter int DataWidth = DefDataWidth
) (
    input  logic                     Clk_i,
    input  logic                     Reset_i,
    extadc_serial_frontend_if.slave  conv_if,
    output logic                     AdcCS_n_o,
    output logic                     AdcSCLK_o,
    input  logic                     AdcMISO_i
);

    localparam int NumBits = LeadBits + DataWidth;
    localparam int IdxW    = cnt_width(NumBits);

    localparam logic [IdxW-1:0] FirstDataIdx = IdxW'(LeadBits);
    localparam logic [IdxW-1:0] LastIdx      = IdxW'(NumBits - 1);

    if (ClkDiv < 1) begin : gen_clkdiv_check
        $error("extadc_serial_frontend: ClkDiv must be at least 1");
    end

    state_e               state_q, state_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DataWidth-1:0] shift_q, shift_d;
    logic [DataWidth-1:0] value_q, value_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 busy_q, busy_d;
    logic                 complete_q, complete_d;

    logic timer_restart;
    logic timer_enable;
    logic phase_end;

    // Timer is held loaded while idle so Setup lasts exactly one full phase.
    assign timer_restart = (state_q == StIdle);
    assign timer_enable  = (state_q == StSetup) || (state_q == StLow) ||
                           (state_q == StHigh)  || (state_q == StHold);

    extadc_phase_timer #(
        .ClkDiv(ClkDiv)
    ) u_phase_timer (
        .Clk_i      (Clk_i),
        .Reset_i    (Reset_i),
        .restart_i  (timer_restart),
        .enable_i   (timer_enable),
        .phase_end_o(phase_end)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        value_d    = value_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        busy_d     = busy_q;
        complete_d = complete_q;

        unique case (state_q)
            StIdle: begin
                if (conv_if.AdcDoConvert) begin
                    state_d = StSetup;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    shift_d = '0;
                end
            end
            StSetup: begin
                if (phase_end) begin
                    state_d = StLow;
                end
            end
            StLow: begin
                if (phase_end) begin
                    state_d = StHigh;
                    sclk_d  = 1'b1;
                    // MISO is captured on the edge that raises SCLK; lead bits are dropped.
                    if (idx_q >= FirstDataIdx) begin
                        shift_d = DataWidth'({shift_q, AdcMISO_i});
                    end
                end
            end
            StHigh: begin
                if (phase_end) begin
                    sclk_d = 1'b0;
                    if (idx_q == LastIdx) begin
                        state_d = StHold;
                    end else begin
                        state_d = StLow;
                        idx_d   = idx_q + IdxW'(1);
                    end
                end
            end
            StHold: begin
                if (phase_end) begin
                    state_d    = StDone;
                    cs_n_d     = 1'b1;
                    busy_d     = 1'b0;
                    value_d    = shift_q;
                    complete_d = 1'b1;
                end
            end
            StDone: begin
                if (!conv_if.AdcDoConvert) begin
                    state_d    = StIdle;
                    complete_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            shift_q    <= '0;
            value_q    <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            value_q    <= value_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
        end
    end

    assign AdcCS_n_o               = cs_n_q;
    assign AdcSCLK_o               = sclk_q;
    assign conv_if.AdcConvComplete = complete_q;
    assign conv_if.AdcValue        = value_q;
    assign conv_if.Busy            = busy_q;

endmodule
